// File: rtl/uart_frame_ctrl.sv
// Receive-side frame controller: sync / length / payload [/ checksum] framing into an external buffer.
// Define UART_FRAME_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module uart_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int        LW             = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          frame_ack,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_wdata,
    output logic          frame_ready,
    output logic [LW-1:0] frame_len,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          dropped,
    output logic          busy,
    output logic [2:0]    dbg_state
);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK     = 3'd3,
`endif
        S_HOLD    = 3'd4
    } state_t;

    state_t        state_q;
    logic          rx_valid_q;
    logic          rx_edge;
    logic [LW-1:0] len_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic [TW-1:0] tmo_q;
    logic          in_frame;
    logic          last_byte;
    logic          len_bad;

    logic          buf_we_q;
    logic [AW-1:0] buf_addr_q;
    logic [7:0]    buf_wdata_q;
    logic          frame_ready_q;
    logic [LW-1:0] frame_len_q;
    logic          frame_err_q;
    logic [1:0]    err_code_q;
    logic          dropped_q;
    logic          busy_q;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]    chk_q;
    logic [7:0]    chk_d;
    assign chk_d = chk_q ^ rx_data;
`endif

    // A held rx_valid level counts as a single byte.
    assign rx_edge   = rx_valid & ~rx_valid_q;
    assign cnt_d     = cnt_q + AW'(1);
    assign last_byte = (LW'(cnt_q) == (len_q - LW'(1)));
    assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign in_frame  = (state_q != S_IDLE) && (state_q != S_HOLD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            rx_valid_q    <= 1'b0;
            len_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            frame_ready_q <= 1'b0;
            frame_len_q   <= '0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            dropped_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            rx_valid_q  <= rx_valid;
            buf_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
            dropped_q   <= 1'b0;

            // Inside a frame a byte edge always beats the timeout.
            if (in_frame && !rx_edge) begin
                if (tmo_q == TMO_LIMIT) begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    frame_err_q <= 1'b1;
                    err_code_q  <= 2'b11;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_edge && (rx_data == SYNC_BYTE)) begin
                            state_q <= S_LEN;
                            busy_q  <= 1'b1;
                            tmo_q   <= '0;
                        end
                    end
                    S_LEN: begin
                        if (rx_edge) begin
                            tmo_q <= '0;
                            if (len_bad) begin
                                state_q     <= S_IDLE;
                                busy_q      <= 1'b0;
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'b01;
                            end else begin
                                state_q <= S_PAYLOAD;
                                len_q   <= LW'(rx_data);
                                cnt_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                                chk_q   <= rx_data;
`endif
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_edge) begin
                            tmo_q       <= '0;
                            buf_we_q    <= 1'b1;
                            buf_addr_q  <= cnt_q;
                            buf_wdata_q <= rx_data;
                            cnt_q       <= cnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
                            chk_q       <= chk_d;
                            if (last_byte) begin
                                state_q <= S_CHK;
                            end
`else
                            if (last_byte) begin
                                state_q       <= S_HOLD;
                                frame_ready_q <= 1'b1;
                                frame_len_q   <= len_q;
                            end
`endif
                        end
                    end
`ifdef UART_FRAME_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_edge) begin
                            tmo_q <= '0;
                            if (rx_data == chk_q) begin
                                state_q       <= S_HOLD;
                                frame_ready_q <= 1'b1;
                                frame_len_q   <= len_q;
                            end else begin
                                state_q     <= S_IDLE;
                                busy_q      <= 1'b0;
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'b10;
                            end
                        end
                    end
`endif
                    S_HOLD: begin
                        if (rx_edge) begin
                            dropped_q <= 1'b1;
                        end
                        if (frame_ack) begin
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                            frame_ready_q <= 1'b0;
                            frame_len_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buf_we      = buf_we_q;
    assign buf_addr    = buf_addr_q;
    assign buf_wdata   = buf_wdata_q;
    assign frame_ready = frame_ready_q;
    assign frame_len   = frame_len_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign dropped     = dropped_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Receive-side frame controller placed directly behind the UART receiver. Consumes the receiver's one-byte strobe and data, delineates byte-oriented command frames (sync, length, payload, checksum), writes payload bytes into an external payload buffer and hands each complete frame to the downstream minimization core with a ready/ack handshake. Detects bad length, checksum mismatch and inter-byte timeout, and drops bytes that arrive while a frame is awaiting acknowledgement.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_LEN, 16, maximum payload length in bytes (1..255)
- TIMEOUT_CYCLES, 2_000_000, maximum CLK cycles between bytes inside a frame (20 ms at 100 MHz)
- AW = $clog2(MAX_LEN) (min 1), LW = $clog2(MAX_LEN+1), derived localparams

- CLK  in  1  system clock, 100 MHz
- RST  in  1  reset, synchronous, active-high
- rx_valid  in  1  byte-received strobe from UART receiver (R_O)
- rx_data  in  8  received byte, stable while rx_valid high
- frame_ack  in  1  consumer has taken the frame
- buf_we  out  1  payload buffer write enable
- buf_addr  out  AW  payload byte index, 0-based
- buf_wdata  out  8  payload byte
- frame_ready  out  1  complete valid frame in buffer
- frame_len  out  LW  payload length of the held frame
- frame_err  out  1  one-cycle error pulse
- err_code  out  2  01 bad length, 10 checksum, 11 timeout; valid with frame_err, holds last value otherwise
- dropped  out  1  one-cycle pulse: byte discarded while frame_ready
- busy  out  1  high in any state other than IDLE

## Operation
- Byte acceptance: rising edge of rx_valid (rx_valid & ~rx_valid_q); a level held N cycles is one byte. rx_valid_q resets to 0.
- States: IDLE, LEN, PAYLOAD, CHK, HOLD.
- IDLE: byte == SYNC_BYTE -> LEN; any other byte ignored silently.
- LEN: byte 0 or > MAX_LEN -> frame_err, err_code=01, IDLE. Otherwise latch length, cnt=0, chk=byte -> PAYLOAD.
- PAYLOAD: each byte: buf_we, buf_addr=cnt, buf_wdata=byte, chk ^= byte, cnt++. On last byte (cnt==len-1) -> CHK (macro on) or HOLD (macro off).
- CHK: byte == chk -> HOLD; else frame_err, err_code=10, IDLE. Buffer contents after error are undefined to consumer.
- HOLD: frame_ready=1, frame_len=len. frame_ack high -> IDLE next cycle. Bytes arriving in HOLD discarded with dropped pulse; a byte and frame_ack in the same cycle: byte discarded (dropped pulses), transition still taken.
- Timeout: counter cleared on every accepted byte and on entry to LEN; counts in LEN, PAYLOAD, CHK; reaching TIMEOUT_CYCLES -> frame_err, err_code=11, IDLE. Timeout and byte in same cycle: byte wins, counter clears. No timeout in IDLE or HOLD.
- SYNC_BYTE value inside LEN/PAYLOAD/CHK is ordinary data, no resync.
- Checksum: 8-bit XOR of length byte and all payload bytes.

## Timing
- All outputs registered. buf_we/addr/wdata, frame_err, dropped asserted the cycle after the rx_valid rising-edge cycle, for exactly one cycle.
- frame_ready rises the cycle after the final (checksum or last payload) byte edge; falls the cycle after frame_ack sampled high.
- Timeout error pulse: cycle after counter reaches TIMEOUT_CYCLES.
- Reset (any state, including mid-frame or HOLD): next cycle state=IDLE, all outputs 0, err_code=00, counters 0, rx_valid_q=0; no buffer write in the reset cycle.
- Byte throughput: one byte per 2 CLK minimum (edge detect); far above UART rate.

## Configuration
- UART_FRAME_CHECKSUM_EN defined: CHK state present, checksum byte required, err_code 10 possible.
- Undefined: CHK state and XOR logic compiled out; frame ends after last payload byte; err_code 10 never produced.

## Test plan
- A5, 03, 11, 22, 33, chk=03^11^22^33=03 -> buf writes (0,11),(1,22),(2,33); frame_ready=1, frame_len=3; frame_ack -> frame_ready=0, IDLE.
- A5, 00 and A5, 11 (MAX_LEN=16) -> frame_err pulse, err_code=01, no buf_we, busy=0.
- A5, 02, 10, 20, checksum FF -> frame_err, err_code=10, frame_ready stays 0 (macro on); macro off: frame_ready after 20, byte FF ignored in IDLE... counted dropped only if still in HOLD.
- A5, 04, 01 then silence TIMEOUT_CYCLES (reduced to 100 in bench) -> frame_err, err_code=11 at cycle 101 after last edge; next A5 starts fresh frame at addr 0.
- Frame completes, 2 bytes sent before frame_ack -> two dropped pulses, frame_len unchanged, buffer not written.
- RST asserted during PAYLOAD after 2 of 5 bytes, rx_valid held high 5 cycles -> IDLE next cycle, all outputs 0; held rx_valid produces no edge, next new A5 frame received correctly.
